// File: rtl/ss_pkg.sv
// Shared definitions for the stretched-pulse arbiter: FSM encoding and width helpers.
package ss_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_PULSE = 1'b1
    } ss_state_e;

    // Bits needed to hold the pulse counter value n.
    function automatic int cnt_width(input int n);
        return $clog2(n + 32'sd1);
    endfunction

    // Bits needed to index n requesters, never less than one.
    function automatic int idx_width(input int n);
        return (n < 32'sd2) ? 32'sd1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: first eligible index after 'last', wrapping modulo NREQ.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int GW   = 2
) (
    input  logic [NREQ-1:0] eligible,
    input  logic [GW-1:0]   last,
    output logic            valid,
    output logic [GW-1:0]   index
);

    logic [GW-1:0] cand_s;
    logic          hit_s;

    // Walk candidates last+1 .. last+NREQ and keep the first hit.
    always_comb begin
        valid  = 1'b0;
        index  = '0;
        cand_s = '0;
        hit_s  = 1'b0;
        for (int i = 32'sd1; i <= NREQ; i++) begin
            cand_s = GW'((int'(last) + i) % NREQ);
            hit_s  = ~valid & eligible[cand_s];
            index  = hit_s ? cand_s : index;
            valid  = valid | hit_s;
        end
    end

endmodule

// File: rtl/ss_arb.sv
// Round-robin arbiter that grants one requester at a time a fixed-width stretched pulse
// on a shared timer; a requester must drop its request before it can be granted again.
module ss_arb
    import ss_pkg::*;
#(
    parameter int   NREQ = 4,
    parameter int   N    = 5,
    parameter logic NE   = 1'b0
) (
    input  logic                          i_clk,
    input  logic                          i_reset_n,
    input  logic [NREQ-1:0]               i_req,
    output logic [NREQ-1:0]               o_pulse,
    output logic                          o_busy,
    output logic [idx_width(NREQ)-1:0]    o_grant_id
);

    localparam int GW = idx_width(NREQ);
    localparam int CW = cnt_width(N);
    localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

    ss_state_e        state_r;
    logic [CW-1:0]    count_r;
    logic [NREQ-1:0]  armed_r;
    logic [NREQ-1:0]  pulse_r;
    logic             busy_r;
    logic [GW-1:0]    grant_r;

    logic [NREQ-1:0]  req_act_s;
    logic [NREQ-1:0]  eligible_s;
    logic             pick_valid_s;
    logic [GW-1:0]    pick_idx_s;
    logic [NREQ-1:0]  pick_mask_s;
    logic [NREQ-1:0]  owner_mask_s;

    assign req_act_s    = i_req ^ {NREQ{NE}};
    assign eligible_s   = armed_r & req_act_s;
    assign pick_mask_s  = pick_valid_s ? (ONE_HOT0 << pick_idx_s) : {NREQ{1'b0}};
    assign owner_mask_s = ONE_HOT0 << grant_r;

    rr_pick #(
        .NREQ (NREQ),
        .GW   (GW)
    ) u_rr_pick (
        .eligible (eligible_s),
        .last     (grant_r),
        .valid    (pick_valid_s),
        .index    (pick_idx_s)
    );

    // Arbitration FSM: owns the shared timer, the arm flags and all registered outputs.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_r <= ST_IDLE;
            count_r <= '0;
            armed_r <= {NREQ{1'b1}};
            pulse_r <= {NREQ{NE}};
            busy_r  <= 1'b0;
            grant_r <= GW'(NREQ - 32'sd1);
        end else begin
            case (state_r)
                ST_IDLE: begin
                    armed_r <= (armed_r | ~req_act_s) & ~pick_mask_s;
                    if (pick_valid_s) begin
                        state_r <= ST_PULSE;
                        count_r <= CW'(N);
                        pulse_r <= {NREQ{NE}} ^ pick_mask_s;
                        busy_r  <= 1'b1;
                        grant_r <= pick_idx_s;
                    end else begin
                        pulse_r <= {NREQ{NE}};
                        busy_r  <= 1'b0;
                    end
                end
                ST_PULSE: begin
                    // The owner stays disarmed for the whole pulse even if its request drops.
                    armed_r <= armed_r | (~req_act_s & ~owner_mask_s);
                    if (count_r > CW'(1)) begin
                        count_r <= count_r - CW'(1);
                    end else begin
                        count_r <= '0;
                        state_r <= ST_IDLE;
                        pulse_r <= {NREQ{NE}};
                        busy_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    count_r <= '0;
                    pulse_r <= {NREQ{NE}};
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign o_pulse    = pulse_r;
    assign o_busy     = busy_r;
    assign o_grant_id = grant_r;

endmodule

// File: tb/tb_ss_arb.sv
// Self-checking bench for ss_arb: a cycle-level behavioural model of the arbitration rules
// plus directed scenarios with hand-computed expectations.
module tb_ss_arb;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req, req2;
    logic [3:0] pulse, pulse2;
    logic       busy, busy2;
    logic [1:0] gid, gid2;

    int vectors  = 0;
    int errors   = 0;
    bit check_en = 1'b0;
    int n;

    always #5 clk = ~clk;

    ss_arb #(.NREQ(4), .N(5), .NE(1'b0)) dut (
        .i_clk (clk), .i_reset_n (rst_n), .i_req (req),
        .o_pulse (pulse), .o_busy (busy), .o_grant_id (gid)
    );

    ss_arb #(.NREQ(4), .N(1), .NE(1'b1)) dut_ne (
        .i_clk (clk), .i_reset_n (rst_n), .i_req (req2),
        .o_pulse (pulse2), .o_busy (busy2), .o_grant_id (gid2)
    );

    // Model: rem = pulse cycles still to show (0 means idle), last = most recent grant.
    typedef struct {
        int         rem;
        int         owner;
        int         last;
        logic [3:0] armed;
    } mdl_t;

    mdl_t m;

    function automatic mdl_t mdl_step(input mdl_t s, input logic [3:0] r);
        mdl_t nx;
        int   g;
        int   c;
        nx = s;
        g  = -1;
        if (s.rem > 0) begin
            for (int k = 0; k < 4; k++)
                if (!r[k] && k != s.owner) nx.armed[k] = 1'b1;
            nx.rem = s.rem - 1;
        end else begin
            for (int k = 0; k < 4; k++)
                if (!r[k]) nx.armed[k] = 1'b1;
            for (int d = 1; d <= 4; d++) begin
                c = (s.last + d) % 4;
                if (g < 0 && s.armed[c] && r[c]) g = c;
            end
            if (g >= 0) begin
                nx.rem      = 5;
                nx.owner    = g;
                nx.last     = g;
                nx.armed[g] = 1'b0;
            end
        end
        return nx;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '{rem: 0, owner: 0, last: 3, armed: 4'b1111};
        else        m <= mdl_step(m, req);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            chk("model_pulse", pulse, (m.rem > 0) ? (4'b0001 << m.owner) : 4'b0000);
            chk("model_busy",  busy,  32'(m.rem > 0));
            chk("model_gid",   gid,   m.last);
            chk("one_hot",     32'($countones(pulse) <= 1), 32'd1);
        end
    end

    task automatic step(input logic [3:0] r);
        req = r;
        @(negedge clk);
    endtask

    task automatic do_reset(input logic [3:0] r);
        rst_n = 1'b0;
        req   = r;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Each slot is 6 cycles; the previous winner drops its request for the slot's first edge.
    task automatic rr_run(input string name, input logic [3:0] base, input logic [9:0] seq);
        logic [3:0] r;
        logic [1:0] g;
        do_reset(base);
        for (int i = 0; i < 30; i++) begin
            r = base;
            if (i % 6 == 0 && i > 0) begin
                g    = seq[2*(i/6-1) +: 2];
                r[g] = 1'b0;
            end
            step(r);
            if (i % 6 == 0) begin
                g = seq[2*(i/6) +: 2];
                chk({name, "_gid"},   gid,   g);
                chk({name, "_pulse"}, pulse, 4'b0001 << g);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 4'b0000;
        req2  = 4'b1111;
        @(negedge clk);
        check_en = 1'b1;
        chk("rst_pulse",    pulse,  4'b0000);
        chk("rst_busy",     busy,   1'b0);
        chk("rst_gid",      gid,    2'd3);
        chk("rst_ne_pulse", pulse2, 4'b1111);
        rst_n = 1'b1;

        // Single held request: one 5-cycle pulse, no repeat while held.
        step(4'b0001);
        chk("a_first_pulse", pulse, 4'b0001);
        chk("a_gid",         gid,   2'd0);
        chk("a_busy",        busy,  1'b1);
        n = 1;
        for (int i = 0; i < 11; i++) begin
            step(4'b0001);
            if (pulse == 4'b0001) n++;
        end
        chk("a_width_held", n, 32'd5);

        // Drop after the pulse re-arms; a drop during the pulse does not.
        step(4'b0000);
        step(4'b0001);
        chk("b_rearm_pulse", pulse, 4'b0001);
        n = 1;
        for (int i = 0; i < 12; i++) begin
            step((i == 1) ? 4'b0000 : 4'b0001);
            if (pulse == 4'b0001) n++;
        end
        chk("b_mid_drop_width", n, 32'd5);
        step(4'b0000);
        step(4'b0001);
        chk("b_second_pulse", pulse, 4'b0001);
        n = 1;
        for (int i = 0; i < 8; i++) begin
            step(4'b0001);
            if (pulse == 4'b0001) n++;
        end
        chk("b_second_width", n, 32'd5);

        rr_run("c_all", 4'b1111, {2'd0, 2'd3, 2'd2, 2'd1, 2'd0});
        rr_run("d_alt", 4'b1010, {2'd1, 2'd3, 2'd1, 2'd3, 2'd1});

        // Asynchronous reset in the middle of a pulse.
        do_reset(4'b0001);
        step(4'b0001);
        step(4'b0001);
        step(4'b0001);
        chk("e_pulse_cycle3", pulse, 4'b0001);
        #2 rst_n = 1'b0;
        #1;
        chk("e_async_pulse", pulse, 4'b0000);
        chk("e_async_busy",  busy,  1'b0);
        chk("e_async_gid",   gid,   2'd3);
        @(negedge clk);
        rst_n = 1'b1;
        step(4'b0100);
        chk("e_regrant_pulse", pulse, 4'b0100);
        chk("e_regrant_gid",   gid,   2'd2);

        // Inverted polarity, single-cycle pulse.
        do_reset(4'b0000);
        req2 = 4'b1110;
        @(negedge clk);
        chk("f_pulse",     pulse2, 4'b1110);
        chk("f_busy",      busy2,  1'b1);
        chk("f_gid",       gid2,   2'd0);
        @(negedge clk);
        chk("f_end_pulse", pulse2, 4'b1111);
        chk("f_end_busy",  busy2,  1'b0);
        @(negedge clk);
        chk("f_held_idle", pulse2, 4'b1111);
        req2 = 4'b1111;
        @(negedge clk);
        req2 = 4'b1110;
        @(negedge clk);
        chk("f_repulse",   pulse2, 4'b1110);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
